fetch_ifid: RTL and testbench

FETCH_IFID -- requirements
Module: fetch_ifid

---
 rtl/fetch_ifid_pkg.sv | 21 ++
 rtl/fetch_ifid_if.sv | 23 ++
 rtl/fetch_ifid_pc_unit.sv | 45 ++++
 rtl/fetch_ifid.sv | 116 +++++++++++
 tb/tb_fetch_ifid.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_ifid_pkg.sv
// Shared pipeline definitions: instruction/PC widths, the ARM NOP used for bubbles,
// the fetch FSM encoding and the sequential-PC helper.
package fetch_ifid_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 64;
  localparam int CNT_W   = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR_ARM = 32'hD503201F;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // Plain modulo-2^64 add: the top word wraps to zero.
  function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/fetch_ifid_if.sv
// Instruction-memory and pipeline-control bundle seen by the fetch stage.
// master = environment (imem + hazard/branch logic), slave = fetch stage.
interface fetch_ifid_if;
  import fetch_ifid_pkg::*;

  logic [INSTR_W-1:0] ibus;
  logic               imem_ready;
  logic               stall;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic [PC_W-1:0]    iaddrbus;

  modport master (
    output ibus, imem_ready, stall, branch_taken, branch_target,
    input  iaddrbus
  );

  modport slave (
    input  ibus, imem_ready, stall, branch_taken, branch_target,
    output iaddrbus
  );

endinterface

// File: rtl/fetch_ifid_pc_unit.sv
// Program counter and next-PC mux; PC is driven straight onto iaddrbus.
// Priority in RUN: branch redirect, then stall / memory-not-ready hold, then PC+4.
module pc_unit
  import fetch_ifid_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  fetch_ifid_if.slave      bus,
  output logic [PC_W-1:0]  pc_o,
  output logic [PC_W-1:0]  pc_plus4_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (run_i) begin
      // Redirect targets are forced word-aligned.
      if (bus.branch_taken) begin
        pc_d = {bus.branch_target[PC_W-1:2], 2'b00};
      end else if (bus.stall || !bus.imem_ready) begin
        pc_d = pc_q;
      end else begin
        pc_d = pc_plus4(pc_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o         = pc_q;
  assign pc_plus4_o   = pc_plus4(pc_q);
  assign bus.iaddrbus = pc_q;

endmodule

// File: rtl/fetch_ifid.sv
// Fetch stage with IF/ID pipeline register and accepted-instruction counter.
// One-cycle BOOT after reset, then fetches one word per cycle unless redirected or held.
module fetch_ifid
  import fetch_ifid_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = 64'h0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_ARM
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] ibus,
  input  logic               imem_ready,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    iaddrbus,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [PC_W-1:0]    ifid_pc_plus4,
  output logic               ifid_valid,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_ifid_if bus_int ();

  assign bus_int.ibus          = ibus;
  assign bus_int.imem_ready    = imem_ready;
  assign bus_int.stall         = stall;
  assign bus_int.branch_taken  = branch_taken;
  assign bus_int.branch_target = branch_target;
  assign iaddrbus              = bus_int.iaddrbus;

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    ifpc_q, ifpc_d;
  logic [PC_W-1:0]    ifpc4_q, ifpc4_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_plus4;
  logic               run;

  assign run = (state_q == RUN);

  pc_unit #(
    .RESET_PC (RESET_PC)
  ) u_pc_unit (
    .clk        (clk),
    .reset      (reset),
    .run_i      (run),
    .bus        (bus_int.slave),
    .pc_o       (pc),
    .pc_plus4_o (pc_plus4)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    ifpc4_d = ifpc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      BOOT: begin
        // Control inputs are ignored here; IF/ID just carries a bubble.
        state_d = RUN;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      RUN: begin
        state_d = RUN;
        if (bus_int.branch_taken) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (bus_int.stall) begin
          instr_d = instr_q;
        end else if (!bus_int.imem_ready) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else begin
          instr_d = bus_int.ibus;
          ifpc_d  = pc;
          ifpc4_d = pc_plus4;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 32'd1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      instr_q <= NOP_INSTR;
      ifpc_q  <= '0;
      ifpc4_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ifpc4_q <= ifpc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ifid_instr    = instr_q;
  assign ifid_pc       = ifpc_q;
  assign ifid_pc_plus4 = ifpc4_q;
  assign ifid_valid    = valid_q;
  assign fetch_count   = cnt_q;

endmodule

// File: tb/tb_fetch_ifid.sv
// Directed bench for fetch_ifid: boot bubble, sequential fetch, stall, branch, imem wait,
// reset priority, and PC wrap on a second instance with RESET_PC at the top word.
module tb_fetch_ifid;

  localparam logic [31:0] NOP  = 32'hD503201F;
  localparam logic [31:0] I0   = 32'h8B020020;
  localparam logic [31:0] I1   = 32'h91000421;
  localparam logic [31:0] I2   = 32'hAA0103E2;
  localparam logic [63:0] TOPW = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_ifid_if fif ();

  logic [31:0] ifid_instr, w_instr;
  logic [63:0] ifid_pc, ifid_pc_plus4, w_iaddr, w_pc, w_pc4;
  logic        ifid_valid, w_valid;
  logic [31:0] fetch_count, w_cnt;

  int vectors = 0;
  int errors  = 0;

  fetch_ifid dut (
    .clk           (clk),
    .reset         (reset),
    .ibus          (fif.ibus),
    .imem_ready    (fif.imem_ready),
    .stall         (fif.stall),
    .branch_taken  (fif.branch_taken),
    .branch_target (fif.branch_target),
    .iaddrbus      (fif.iaddrbus),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid),
    .fetch_count   (fetch_count)
  );

  fetch_ifid #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk           (clk),
    .reset         (reset),
    .ibus          (fif.ibus),
    .imem_ready    (fif.imem_ready),
    .stall         (fif.stall),
    .branch_taken  (fif.branch_taken),
    .branch_target (fif.branch_target),
    .iaddrbus      (w_iaddr),
    .ifid_instr    (w_instr),
    .ifid_pc       (w_pc),
    .ifid_pc_plus4 (w_pc4),
    .ifid_valid    (w_valid),
    .fetch_count   (w_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fif.ibus          = I0;
    fif.imem_ready    = 1'b1;
    fif.stall         = 1'b0;
    fif.branch_taken  = 1'b0;
    fif.branch_target = 64'h0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    fif.stall = 1'b1;
    fif.branch_taken = 1'b1;
    fif.branch_target = 64'h500;
    apply_reset();
    vectors++; if (fif.iaddrbus !== 64'h0) begin errors++; $display("FAIL rst_iaddr got %h exp %h", fif.iaddrbus, 64'h0); end
    vectors++; if (ifid_instr !== NOP) begin errors++; $display("FAIL rst_instr got %h exp %h", ifid_instr, NOP); end
    vectors++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", ifid_valid); end
    vectors++; if (ifid_pc !== 64'h0) begin errors++; $display("FAIL rst_ifpc got %h exp 0", ifid_pc); end
    vectors++; if (ifid_pc_plus4 !== 64'h0) begin errors++; $display("FAIL rst_ifpc4 got %h exp 0", ifid_pc_plus4); end
    vectors++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", fetch_count); end
    vectors++; if (w_iaddr !== TOPW) begin errors++; $display("FAIL rst_wrap_iaddr got %h exp %h", w_iaddr, TOPW); end
    // BOOT edge with branch/stall asserted: nothing may move
    step();
    vectors++; if (fif.iaddrbus !== 64'h0) begin errors++; $display("FAIL boot_ignore_iaddr got %h exp 0", fif.iaddrbus); end
    vectors++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL boot_ignore_valid got %b exp 0", ifid_valid); end
    idle_inputs();
  endtask

  task automatic test_boot_fetch();
    idle_inputs();
    apply_reset();
    step();
    vectors++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got %b exp 0", ifid_valid); end
    vectors++; if (fif.iaddrbus !== 64'h0) begin errors++; $display("FAIL boot_iaddr got %h exp 0", fif.iaddrbus); end
    vectors++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL boot_cnt got %0d exp 0", fetch_count); end
    step();
    vectors++; if (ifid_pc !== 64'h0) begin errors++; $display("FAIL f0_pc got %h exp 0", ifid_pc); end
    vectors++; if (ifid_pc_plus4 !== 64'h4) begin errors++; $display("FAIL f0_pc4 got %h exp 4", ifid_pc_plus4); end
    vectors++; if (ifid_instr !== I0) begin errors++; $display("FAIL f0_instr got %h exp %h", ifid_instr, I0); end
    vectors++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL f0_valid got %b exp 1", ifid_valid); end
    vectors++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL f0_cnt got %0d exp 1", fetch_count); end
    vectors++; if (fif.iaddrbus !== 64'h4) begin errors++; $display("FAIL f0_iaddr got %h exp 4", fif.iaddrbus); end
    step();
    vectors++; if (ifid_pc !== 64'h4) begin errors++; $display("FAIL f1_pc got %h exp 4", ifid_pc); end
    vectors++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL f1_cnt got %0d exp 2", fetch_count); end
    step();
    vectors++; if (ifid_pc !== 64'h8) begin errors++; $display("FAIL f2_pc got %h exp 8", ifid_pc); end
    vectors++; if (ifid_pc_plus4 !== 64'hC) begin errors++; $display("FAIL f2_pc4 got %h exp c", ifid_pc_plus4); end
    vectors++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL f2_cnt got %0d exp 3", fetch_count); end
  endtask

  // Continues from PC=0xC, count=3.
  task automatic test_stall();
    fif.ibus = I1;
    step();
    vectors++; if (fif.iaddrbus !== 64'h10) begin errors++; $display("FAIL pre_stall_iaddr got %h exp 10", fif.iaddrbus); end
    vectors++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL pre_stall_cnt got %0d exp 4", fetch_count); end
    fif.stall = 1'b1;
    fif.ibus  = I2;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++; if (fif.iaddrbus !== 64'h10) begin errors++; $display("FAIL stall_iaddr[%0d] got %h exp 10", i, fif.iaddrbus); end
      vectors++; if (ifid_instr !== I1) begin errors++; $display("FAIL stall_instr[%0d] got %h exp %h", i, ifid_instr, I1); end
      vectors++; if (ifid_pc !== 64'hC) begin errors++; $display("FAIL stall_ifpc[%0d] got %h exp c", i, ifid_pc); end
      vectors++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", i, ifid_valid); end
      vectors++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL stall_cnt[%0d] got %0d exp 4", i, fetch_count); end
    end
    fif.stall = 1'b0;
    step();
    vectors++; if (ifid_pc !== 64'h10) begin errors++; $display("FAIL resume_ifpc got %h exp 10", ifid_pc); end
    vectors++; if (ifid_instr !== I2) begin errors++; $display("FAIL resume_instr got %h exp %h", ifid_instr, I2); end
    vectors++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL resume_cnt got %0d exp 5", fetch_count); end
    vectors++; if (fif.iaddrbus !== 64'h14) begin errors++; $display("FAIL resume_iaddr got %h exp 14", fif.iaddrbus); end
  endtask

  // Continues with fetch_count=5; reset lands in the middle of a stall.
  task automatic test_reset_in_stall();
    fif.stall = 1'b1;
    step();
    vectors++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL rs_pre_cnt got %0d exp 5", fetch_count); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++; if (fif.iaddrbus !== 64'h0) begin errors++; $display("FAIL rs_iaddr got %h exp 0", fif.iaddrbus); end
    vectors++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL rs_cnt got %0d exp 0", fetch_count); end
    vectors++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rs_valid got %b exp 0", ifid_valid); end
    fif.stall = 1'b0;
    fif.ibus  = I0;
    step();
    // BOOT: no fetch even though inputs request one
    vectors++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL rs_boot_cnt got %0d exp 0", fetch_count); end
    vectors++; if (fif.iaddrbus !== 64'h0) begin errors++; $display("FAIL rs_boot_iaddr got %h exp 0", fif.iaddrbus); end
    step();
    vectors++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL rs_run_cnt got %0d exp 1", fetch_count); end
    vectors++; if (fif.iaddrbus !== 64'h4) begin errors++; $display("FAIL rs_run_iaddr got %h exp 4", fif.iaddrbus); end
  endtask

  // Continues from PC=4, IF/ID pc=0, count=1.
  task automatic test_branch();
    fif.branch_taken  = 1'b1;
    fif.stall         = 1'b1;
    fif.branch_target = 64'h203;
    step();
    vectors++; if (fif.iaddrbus !== 64'h200) begin errors++; $display("FAIL br_iaddr got %h exp 200", fif.iaddrbus); end
    vectors++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL br_valid got %b exp 0", ifid_valid); end
    vectors++; if (ifid_instr !== NOP) begin errors++; $display("FAIL br_instr got %h exp %h", ifid_instr, NOP); end
    vectors++; if (ifid_pc !== 64'h0) begin errors++; $display("FAIL br_ifpc_hold got %h exp 0", ifid_pc); end
    vectors++; if (ifid_pc_plus4 !== 64'h4) begin errors++; $display("FAIL br_ifpc4_hold got %h exp 4", ifid_pc_plus4); end
    vectors++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL br_cnt got %0d exp 1", fetch_count); end
    fif.branch_taken = 1'b0;
    fif.stall        = 1'b0;
    fif.ibus         = I1;
    step();
    vectors++; if (ifid_pc !== 64'h200) begin errors++; $display("FAIL br_tgt_ifpc got %h exp 200", ifid_pc); end
    vectors++; if (ifid_instr !== I1) begin errors++; $display("FAIL br_tgt_instr got %h exp %h", ifid_instr, I1); end
    vectors++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL br_tgt_cnt got %0d exp 2", fetch_count); end
  endtask

  // Redirect to 0x40, then one not-ready cycle.
  task automatic test_imem_wait();
    fif.branch_taken  = 1'b1;
    fif.branch_target = 64'h40;
    step();
    fif.branch_taken = 1'b0;
    vectors++; if (fif.iaddrbus !== 64'h40) begin errors++; $display("FAIL nr_pre_iaddr got %h exp 40", fif.iaddrbus); end
    fif.imem_ready = 1'b0;
    step();
    vectors++; if (fif.iaddrbus !== 64'h40) begin errors++; $display("FAIL nr_iaddr got %h exp 40", fif.iaddrbus); end
    vectors++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL nr_valid got %b exp 0", ifid_valid); end
    vectors++; if (ifid_instr !== NOP) begin errors++; $display("FAIL nr_instr got %h exp %h", ifid_instr, NOP); end
    vectors++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL nr_cnt got %0d exp 2", fetch_count); end
    fif.imem_ready = 1'b1;
    fif.ibus       = I2;
    step();
    vectors++; if (ifid_pc !== 64'h40) begin errors++; $display("FAIL nr_cap_ifpc got %h exp 40", ifid_pc); end
    vectors++; if (ifid_instr !== I2) begin errors++; $display("FAIL nr_cap_instr got %h exp %h", ifid_instr, I2); end
    vectors++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL nr_cap_valid got %b exp 1", ifid_valid); end
    vectors++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL nr_cap_cnt got %0d exp 3", fetch_count); end
    vectors++; if (fif.iaddrbus !== 64'h44) begin errors++; $display("FAIL nr_cap_iaddr got %h exp 44", fif.iaddrbus); end
  endtask

  task automatic test_pc_wrap();
    idle_inputs();
    apply_reset();
    step();
    vectors++; if (w_iaddr !== TOPW) begin errors++; $display("FAIL wrap_boot_iaddr got %h exp %h", w_iaddr, TOPW); end
    step();
    vectors++; if (w_pc !== TOPW) begin errors++; $display("FAIL wrap_ifpc got %h exp %h", w_pc, TOPW); end
    vectors++; if (w_pc4 !== 64'h0) begin errors++; $display("FAIL wrap_ifpc4 got %h exp 0", w_pc4); end
    vectors++; if (w_iaddr !== 64'h0) begin errors++; $display("FAIL wrap_iaddr got %h exp 0", w_iaddr); end
    vectors++; if (w_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b exp 1", w_valid); end
    vectors++; if (w_cnt !== 32'd1) begin errors++; $display("FAIL wrap_cnt got %0d exp 1", w_cnt); end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    test_reset();
    test_boot_fetch();
    test_stall();
    test_reset_in_stall();
    test_branch();
    test_imem_wait();
    test_pc_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
